// File: rtl/spi_xfer_seq_if.sv
// Byte-level handshake between the transfer sequencer and the single-byte SPI interface.
// master = sequencer side, slave = SPI interface side.
interface spi_xfer_seq_if;
   logic [7:0] spi_din;
   logic       spi_cmd;
   logic       spi_wr;
   logic       spi_rd;
   logic [7:0] spi_dout;
   logic       spi_irq;

   modport master (
      output spi_din,
      output spi_cmd,
      output spi_wr,
      output spi_rd,
      input  spi_dout,
      input  spi_irq
   );

   modport slave (
      input  spi_din,
      input  spi_cmd,
      input  spi_wr,
      input  spi_rd,
      output spi_dout,
      output spi_irq
   );
endinterface

// File: rtl/spi_xfer_seq.sv
// Multi-byte SPI transfer sequencer: sends a config byte, then streams TX buffer bytes
// through the single-byte SPI interface, captures replies into the RX buffer, aborts on timeout.
module spi_xfer_seq #(
   parameter int unsigned AW    = 4,
   parameter int unsigned TMO_W = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [AW-1:0]   len_i,
   input  logic [7:0]      cfg_byte_i,
   input  logic            tx_we_i,
   input  logic [AW-1:0]   tx_addr_i,
   input  logic [7:0]      tx_data_i,
   input  logic [AW-1:0]   rx_addr_i,
   output logic [7:0]      rx_data_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   spi_xfer_seq_if.master  spi
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned DW    = 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CFG   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;
   localparam logic [2:0] S_ABORT = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    last_q, last_d;
   logic [DW-1:0]    cfg_q, cfg_d;
   logic [TMO_W-1:0] wdog_q, wdog_d;
   logic [TMO_W-1:0] wdog_inc;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cmd_q, cmd_d;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic [DW-1:0]    din_q, din_d;
   logic [DW-1:0]    rx_data_q;
   logic             rx_we;

   logic [DW-1:0]    tx_buf [DEPTH];
   logic [DW-1:0]    rx_buf [DEPTH];

   assign wdog_inc = wdog_q + TMO_W'(1);

   // Next-state logic; registered outputs are decoded from the next state so they
   // are valid during the cycle the FSM occupies the matching state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cfg_d   = cfg_q;
      wdog_d  = wdog_q;
      err_d   = err_q;
      rx_we   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               last_d  = len_i - AW'(1);
               cfg_d   = cfg_byte_i;
               err_d   = 1'b0;
               idx_d   = '0;
               state_d = S_CFG;
            end
         end
         S_CFG: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (spi.spi_irq) begin
               rx_we   = 1'b1;
               state_d = S_ACK;
            end else begin
               wdog_d = wdog_inc;
               if (wdog_inc == '1) begin
                  err_d   = 1'b1;
                  state_d = S_ABORT;
               end
            end
         end
         S_ACK: begin
            if (idx_q == last_q) begin
               state_d = S_FIN;
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = S_LOAD;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cmd_d  = (state_d == S_CFG);
      wr_d   = (state_d == S_LOAD);
      rd_d   = (state_d == S_ACK) || (state_d == S_ABORT);
      done_d = (state_d == S_FIN);
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);

      din_d = din_q;
      if (state_d == S_CFG) begin
         din_d = cfg_d;
      end else if (state_d == S_LOAD) begin
         din_d = tx_buf[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         cfg_q     <= '0;
         wdog_q    <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cmd_q     <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         din_q     <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         cfg_q     <= cfg_d;
         wdog_q    <= wdog_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cmd_q     <= cmd_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         din_q     <= din_d;
         rx_data_q <= rx_buf[rx_addr_i];
      end
   end

   // Buffer storage is deliberately left out of reset; a capture racing rst is dropped.
   always_ff @(posedge clk) begin
      if (tx_we_i) begin
         tx_buf[tx_addr_i] <= tx_data_i;
      end
      if (rx_we && !rst) begin
         rx_buf[idx_q] <= spi.spi_dout;
      end
   end

   assign rx_data_o   = rx_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign spi.spi_din = din_q;
   assign spi.spi_cmd = cmd_q;
   assign spi.spi_wr  = wr_q;
   assign spi.spi_rd  = rd_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: reactive SPI byte model, expected-event scoreboard and RX buffer model.
module tb_spi_xfer_seq;
   localparam int unsigned AW    = 4;
   localparam int unsigned TMO_W = 4;
   localparam int unsigned DEPTH = 16;

   localparam logic [2:0] EV_CMD  = 3'd1;
   localparam logic [2:0] EV_WR   = 3'd2;
   localparam logic [2:0] EV_RD   = 3'd3;
   localparam logic [2:0] EV_DONE = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] din;
   } evt_t;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          start   = 1'b0;
   logic [AW-1:0] len     = '0;
   logic [7:0]    cfg     = 8'h00;
   logic          tx_we   = 1'b0;
   logic [AW-1:0] tx_addr = '0;
   logic [7:0]    tx_data = 8'h00;
   logic [AW-1:0] rx_addr = '0;
   logic [7:0]    rx_data;
   logic          busy;
   logic          done;
   logic          err;

   logic          irq_real = 1'b0;
   logic          spur     = 1'b0;
   logic [7:0]    dout_r   = 8'h00;

   spi_xfer_seq_if sif ();
   assign sif.spi_irq  = irq_real | spur;
   assign sif.spi_dout = dout_r;

   spi_xfer_seq #(.AW(AW), .TMO_W(TMO_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start),
      .len_i      (len),
      .cfg_byte_i (cfg),
      .tx_we_i    (tx_we),
      .tx_addr_i  (tx_addr),
      .tx_data_i  (tx_data),
      .rx_addr_i  (rx_addr),
      .rx_data_o  (rx_data),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .spi        (sif)
   );

   always #5 clk = ~clk;

   logic [7:0]  tx_m [DEPTH];
   logic [7:0]  rx_m [DEPTH];
   bit          rx_ok [DEPTH];
   evt_t        exp_q [$];
   int          total = 0;
   int          bad   = 0;
   int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   longint      cyc = 0, last_wr = -1;
   bit          gap_chk = 1'b0;
   bit          irq_en  = 1'b1;
   int unsigned dly_max = 0;
   logic [7:0]  key     = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_evt(input logic [2:0] k, input logic [7:0] d);
      evt_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_spi_evt", {21'd0, k, d}, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("spi_evt", {21'd0, k, d}, {21'd0, e.kind, e.din});
      end
   endtask

   // SPI byte model: reply (din ^ key) some cycles after each load, drop irq on acknowledge.
   bit          pend = 1'b0;
   int unsigned pend_cnt = 0;
   logic [7:0]  lw = 8'h00;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         irq_real = 1'b0;
         pend     = 1'b0;
      end else begin
         if (sif.spi_rd) begin
            irq_real = 1'b0;
            pend     = 1'b0;
         end
         if (sif.spi_wr) begin
            pend     = 1'b1;
            pend_cnt = $urandom_range(dly_max);
            lw       = sif.spi_din;
         end
         if (pend && irq_en) begin
            if (pend_cnt == 0) begin
               irq_real = 1'b1;
               dout_r   = lw ^ key;
               pend     = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
      end
   end

   // Every strobe the DUT issues must be the next entry of the expected event list.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         if (sif.spi_cmd) chk_evt(EV_CMD, sif.spi_din);
         if (sif.spi_wr) begin
            chk_evt(EV_WR, sif.spi_din);
            if (gap_chk && last_wr >= 0) check("wr_gap_min", 32'(cyc - last_wr), 32'd3);
            last_wr = cyc;
            wr_cnt++;
         end
         if (sif.spi_rd) begin
            chk_evt(EV_RD, 8'h00);
            rd_cnt++;
         end
         if (done) begin
            chk_evt(EV_DONE, 8'h00);
            check("busy_low_at_done", 32'(busy), 32'd0);
            done_cnt++;
         end
      end
   end

   task automatic wr_tx(input int a, input logic [7:0] d);
      tx_we   = 1'b1;
      tx_addr = AW'(a);
      tx_data = d;
      tx_m[a] = d;
      @(negedge clk);
      tx_we   = 1'b0;
   endtask

   function automatic int nbytes(input logic [AW-1:0] l);
      return (l == '0) ? DEPTH : int'(l);
   endfunction

   task automatic push_xfer(input int n, input logic [7:0] c);
      exp_q.push_back('{kind: EV_CMD, din: c});
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{kind: EV_WR, din: tx_m[i]});
         exp_q.push_back('{kind: EV_RD, din: 8'h00});
      end
      exp_q.push_back('{kind: EV_DONE, din: 8'h00});
   endtask

   task automatic commit_rx(input int n);
      for (int i = 0; i < n; i++) begin
         rx_m[i]  = tx_m[i] ^ key;
         rx_ok[i] = 1'b1;
      end
   endtask

   // Pulse start; ends at the negedge of the LOAD cycle of byte 0.
   task automatic start_xfer(input logic [AW-1:0] l, input logic [7:0] c, input logic sp);
      start   = 1'b1;
      len     = l;
      cfg     = c;
      spur    = sp;
      last_wr = -1;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", 32'(busy), 32'd1);
      check("cmd_strobe", 32'(sif.spi_cmd), 32'd1);
      check("cmd_din", 32'(sif.spi_din), 32'(c));
      check("err_clear_on_start", 32'(err), 32'd0);
      @(negedge clk);
      spur = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("idle_reached", 32'(ok), 32'd1);
   endtask

   task automatic wait_wr(input int target);
      bit ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (wr_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("wr_reached", 32'(ok), 32'd1);
   endtask

   task automatic finish_normal(input int d0);
      wait_idle();
      check("done_at_fin", 32'(done), 32'd1);
      repeat (2) @(negedge clk);
      check("evt_queue_drained", 32'(exp_q.size()), 32'd0);
      check("err_after_xfer", 32'(err), 32'd0);
      check("done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   task automatic run_xfer(input logic [AW-1:0] l, input logic [7:0] c, input logic sp);
      int d0 = done_cnt;
      push_xfer(nbytes(l), c);
      commit_rx(nbytes(l));
      start_xfer(l, c, sp);
      finish_normal(d0);
   endtask

   task automatic rd_rx(input int a, output logic [7:0] v);
      rx_addr = AW'(a);
      @(negedge clk);
      v = rx_data;
   endtask

   task automatic read_rx_all();
      logic [7:0] v;
      for (int a = 0; a < DEPTH; a++) begin
         if (rx_ok[a]) begin
            rd_rx(a, v);
            check("rx_buf", 32'(v), 32'(rx_m[a]));
         end
      end
   endtask

   initial begin
      logic [7:0] v;
      int         d0, wb, rc;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_flags", 32'({busy, done, err, sif.spi_cmd, sif.spi_wr, sif.spi_rd}), 32'd0);
      check("rst_din", 32'(sif.spi_din), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Three-byte loopback transfer
      key = 8'h00; dly_max = 2;
      wr_tx(0, 8'hA5); wr_tx(1, 8'h3C); wr_tx(2, 8'hFF);
      run_xfer(AW'(3), 8'h04, 1'b0);
      rd_rx(0, v); check("t1_rx0", 32'(v), 32'hA5);
      rd_rx(1, v); check("t1_rx1", 32'(v), 32'h3C);
      rd_rx(2, v); check("t1_rx2", 32'(v), 32'hFF);
      check("t1_busy_low", 32'(busy), 32'd0);

      // Spurious irq while idle
      rc = rd_cnt;
      spur = 1'b1;
      repeat (3) @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      check("spur_idle_busy", 32'(busy), 32'd0);
      check("spur_idle_rd", 32'(rd_cnt - rc), 32'd0);
      rd_rx(0, v); check("spur_idle_rx0", 32'(v), 32'hA5);

      // Spurious irq across IDLE->CFG
      key = 8'h5A;
      wr_tx(0, 8'h12); wr_tx(1, 8'h9E);
      run_xfer(AW'(2), 8'h84, 1'b1);
      read_rx_all();

      // len=0: full 16-byte ramp at minimum per-byte spacing
      key = 8'h00; dly_max = 0; gap_chk = 1'b1;
      for (int a = 0; a < DEPTH; a++) wr_tx(a, 8'(a));
      run_xfer(AW'(0), 8'h04, 1'b0);
      gap_chk = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_rx(a, v);
         check("t2_rx_ramp", 32'(v), 32'(a));
      end

      // Timeout: no irq from the SPI model
      irq_en = 1'b0; dly_max = 1;
      d0 = done_cnt;
      exp_q.push_back('{kind: EV_CMD, din: 8'h24});
      exp_q.push_back('{kind: EV_WR, din: tx_m[0]});
      exp_q.push_back('{kind: EV_RD, din: 8'h00});
      start_xfer(AW'(2), 8'h24, 1'b0);
      repeat (15) @(negedge clk);
      check("tmo_err_early", 32'(err), 32'd0);
      check("tmo_busy_wait", 32'(busy), 32'd1);
      @(negedge clk);
      check("tmo_err_set", 32'(err), 32'd1);
      check("tmo_abort_rd", 32'(sif.spi_rd), 32'd1);
      @(negedge clk);
      check("tmo_busy_low", 32'(busy), 32'd0);
      check("tmo_err_sticky", 32'(err), 32'd1);
      repeat (3) @(negedge clk);
      check("tmo_err_held", 32'(err), 32'd1);
      check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
      check("tmo_queue", 32'(exp_q.size()), 32'd0);
      irq_en = 1'b1; key = 8'h33;
      run_xfer(AW'(3), 8'h04, 1'b0);
      read_rx_all();

      // Start while busy, during WAIT of byte 1
      key = 8'hC3; dly_max = 3;
      d0 = done_cnt;
      push_xfer(4, 8'h06);
      commit_rx(4);
      wb = wr_cnt;
      start_xfer(AW'(4), 8'h06, 1'b0);
      wait_wr(wb + 2);
      @(negedge clk);
      start = 1'b1; len = AW'(7); cfg = 8'hEE;
      @(negedge clk);
      start = 1'b0;
      finish_normal(d0);
      repeat (6) @(negedge clk);
      check("busy_start_idle", 32'(busy), 32'd0);
      check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
      read_rx_all();

      // Reset during WAIT of byte 2
      key = 8'h71; dly_max = 3;
      push_xfer(5, 8'h0C);
      wb = wr_cnt;
      start_xfer(AW'(5), 8'h0C, 1'b0);
      wait_wr(wb + 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_flags", 32'({busy, done, err, sif.spi_cmd, sif.spi_wr, sif.spi_rd}), 32'd0);
      check("rst_mid_din", 32'(sif.spi_din), 32'd0);
      exp_q.delete();
      commit_rx(2);
      @(negedge clk);
      key = 8'h0F;
      run_xfer(AW'(3), 8'h04, 1'b0);
      read_rx_all();

      // Randomized transfers
      for (int it = 0; it < 8; it++) begin
         key     = 8'($urandom);
         dly_max = $urandom_range(4);
         for (int a = 0; a < DEPTH; a++) wr_tx(a, 8'($urandom));
         run_xfer(AW'($urandom_range(15)), 8'($urandom) | 8'h04, 1'b0);
         read_rx_all();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

endmodule
